// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain
// Description : Read stage of the replay-buffer fifo controller. Pops the fifo
//               while the 2-entry output buffer has credit, passes the fifo
//               read pointer to the storage RAM and captures the RAM word one
//               cycle later. Presents the buffer head on a valid/ready stream
//               at up to one word per cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous active-high reset
//   fifo_empty   in   1       fifo controller empty flag
//   fifo_r_addr  in   ADDR_W  fifo controller read pointer
//   fifo_rd      out  1       pop request to fifo controller
//   ram_addr     out  ADDR_W  storage RAM read address
//   ram_rdata    in   DATA_W  RAM read data, valid one cycle after ram_addr
//   out_valid    out  1       out_data holds a word
//   out_data     out  DATA_W  head word of output buffer
//   out_ready    in   1       consumer accepts the word this cycle
//   flush        in   1       discard buffered and in-flight words
//   pop_count    out  CNT_W   words delivered since reset (wraps)
// ============================================================================
module fifo_drain #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [ADDR_W-1:0] fifo_r_addr,
  output logic              fifo_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  pop_count
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t              r_occ;
  logic              r_valid;
  logic              r_inflight;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [CNT_W-1:0]  r_pop_count;

  logic              w_pop;
  logic              w_capture;
  logic [2:0]        w_level;

  assign w_pop     = r_valid & out_ready;
  assign w_capture = r_inflight;

  // Credit: words buffered plus the word in flight, less the one leaving
  // this cycle. Issuing only while this is below 2 guarantees a captured
  // word always finds a free slot, even with out_ready low.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_rd = !reset && !flush && !fifo_empty && (w_level < 3'd2);

  assign ram_addr  = fifo_r_addr;
  assign out_valid = r_valid;
  assign out_data  = r_head;
  assign pop_count = r_pop_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ       <= EMPTY;
      r_valid     <= 1'b0;
      r_inflight  <= 1'b0;
      r_head      <= '0;
      r_tail      <= '0;
      r_pop_count <= '0;
    end else begin
      r_inflight <= fifo_rd;
      // A word accepted in the flush cycle is still counted as delivered.
      if (w_pop) begin
        r_pop_count <= r_pop_count + c_CNT_ONE;
      end
      if (flush) begin
        // Buffered words and the RAM word arriving now are dropped.
        r_occ   <= EMPTY;
        r_valid <= 1'b0;
      end else begin
        case (r_occ)
          EMPTY: begin
            if (w_capture) begin
              r_head  <= ram_rdata;
              r_occ   <= ONE;
              r_valid <= 1'b1;
            end
          end
          ONE: begin
            if (w_capture && w_pop) begin
              r_head <= ram_rdata;
            end else if (w_capture) begin
              r_tail <= ram_rdata;
              r_occ  <= TWO;
            end else if (w_pop) begin
              r_occ   <= EMPTY;
              r_valid <= 1'b0;
            end
          end
          TWO: begin
            // Capture without a pop cannot happen here: credit is exhausted.
            if (w_pop) begin
              r_head <= r_tail;
              if (w_capture) begin
                r_tail <= ram_rdata;
              end else begin
                r_occ <= ONE;
              end
            end
          end
          default: begin
            r_occ   <= EMPTY;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_drain
// Description : Bench for fifo_drain. Surrounds the design with an 8-deep fifo
//               controller and a 1-cycle synchronous RAM. A reference model
//               tracks fetched-but-undelivered words as a queue stamped with
//               their fetch cycle and checks every cycle; directed scenarios
//               add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_drain;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic [2:0] fifo_r_addr;
  logic       fifo_rd;
  logic [2:0] ram_addr;
  logic [7:0] ram_rdata = 8'h00;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       flush;
  logic [15:0] pop_count;

  logic       wr_en;
  logic [7:0] wr_data;

  int nchk = 0;
  int nerr = 0;

  fifo_drain #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_r_addr(fifo_r_addr),
    .fifo_rd    (fifo_rd),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .flush      (flush),
    .pop_count  (pop_count)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Environment: fifo controller (not affected by the drain's reset) + RAM
  // --------------------------------------------------------------------------
  logic [7:0] mem [8];
  int cnt  = 0;
  int wptr = 0;
  int rptr = 0;

  assign fifo_empty  = (cnt == 0);
  assign fifo_r_addr = rptr[2:0];

  always @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wr_data;
      wptr      <= (wptr + 1) % 8;
    end
    if (fifo_rd) rptr <= (rptr + 1) % 8;
    cnt       <= cnt + (wr_en ? 1 : 0) - (fifo_rd ? 1 : 0);
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model and per-cycle compare. Inputs change just after the rising
  // edge, so at the falling edge every signal holds the value the next rising
  // edge will act on.
  // --------------------------------------------------------------------------
  logic [7:0] wq[$];       // words in the fifo, write order
  logic [7:0] pend_d[$];   // fetched, not yet delivered
  int         pend_t[$];   // cycle each pending word was fetched
  int         rd_cyc[$];
  int         rd_addr[$];
  logic [7:0] dlv_data[$];
  int         dlv_cyc[$];
  int         cyc = 0;
  int         mcnt = 0;
  logic       rst_seen = 1'b0;

  always @(negedge clk) begin
    logic exp_valid;
    logic exp_pop;
    logic exp_rd;
    int   lvl;
    exp_valid = (pend_d.size() > 0) && (pend_t[0] + 2 <= cyc);
    exp_pop   = exp_valid && out_ready;
    lvl       = pend_d.size() - (exp_pop ? 1 : 0);
    exp_rd    = !reset && !flush && !fifo_empty && (lvl < 2);
    chk("fifo_rd", fifo_rd, exp_rd);
    if (cyc > 0) begin
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) chk("out_data", out_data, pend_d[0]);
      chk("pop_count", pop_count, mcnt);
      if (reset && rst_seen) chk("out_data_in_reset", out_data, 0);
    end
    rst_seen = reset;
    if (reset) begin
      pend_d.delete();
      pend_t.delete();
      mcnt = 0;
    end else begin
      if (exp_pop) begin
        dlv_data.push_back(pend_d.pop_front());
        void'(pend_t.pop_front());
        dlv_cyc.push_back(cyc);
        mcnt = (mcnt + 1) % 65536;
      end
      if (flush) begin
        pend_d.delete();
        pend_t.delete();
      end
      if (fifo_rd) begin
        chk("rd_has_word", int'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          pend_d.push_back(wq.pop_front());
          pend_t.push_back(cyc);
          rd_cyc.push_back(cyc);
          rd_addr.push_back(int'(ram_addr));
        end
      end
      // The credit rule must never let buffered + in-flight exceed 2.
      if (pend_d.size() > 2) chk("buf_overflow", pend_d.size(), 2);
    end
    if (wr_en) wq.push_back(wr_data);
    cyc++;
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dlv(input int target, input int budget, input string nm);
    int k = 0;
    while (dlv_data.size() < target && k < budget) begin
      step();
      k++;
    end
    chk(nm, dlv_data.size(), target);
  endtask

  task automatic write_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(base + i);
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int m_r;
    int m_d;
    int written;
    int k;
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    step();

    // 1: reset held with a non-empty fifo (A1..A3 loaded during reset)
    write_words(8'hA1, 3);
    step();
    step();
    chk("t1_fifo_not_empty", fifo_empty, 0);
    chk("t1_rd_in_reset", fifo_rd, 0);
    chk("t1_valid_in_reset", out_valid, 0);
    chk("t1_data_in_reset", out_data, 0);
    chk("t1_count_in_reset", pop_count, 0);

    // 2: release reset, consumer ready: three back-to-back words
    m_r = rd_cyc.size();
    m_d = dlv_data.size();
    out_ready = 1'b1;
    reset     = 1'b0;
    wait_dlv(m_d + 3, 20, "t2_timeout");
    chk("t2_rd_pulses", rd_cyc.size() - m_r, 3);
    chk("t2_rd_consec1", rd_cyc[m_r+1] - rd_cyc[m_r], 1);
    chk("t2_rd_consec2", rd_cyc[m_r+2] - rd_cyc[m_r+1], 1);
    chk("t2_latency", dlv_cyc[m_d] - rd_cyc[m_r], 2);
    chk("t2_word0", dlv_data[m_d], 8'hA1);
    chk("t2_word1", dlv_data[m_d+1], 8'hA2);
    chk("t2_word2", dlv_data[m_d+2], 8'hA3);
    chk("t2_back2back", dlv_cyc[m_d+2] - dlv_cyc[m_d], 2);
    chk("t2_pop_count", pop_count, 3);

    // 3: 8 words with consumer stalled: only 2 fetched, then full-rate drain
    out_ready = 1'b0;
    m_r = rd_cyc.size();
    m_d = dlv_data.size();
    write_words(8'hC0, 8);
    repeat (6) step();
    chk("t3_rd_pulses", rd_cyc.size() - m_r, 2);
    chk("t3_fifo_left", cnt, 6);
    chk("t3_valid_stalled", out_valid, 1);
    out_ready = 1'b1;
    wait_dlv(m_d + 8, 40, "t3_timeout");
    for (int i = 0; i < 8; i++) chk("t3_word", dlv_data[m_d+i], 8'(8'hC0 + i));
    chk("t3_no_bubble", dlv_cyc[m_d+7] - dlv_cyc[m_d], 7);
    chk("t3_pop_count", pop_count, 11);  // 3 from scenario 2 + 8

    // 4: two batches of 8; read pointer starts at 3 and wraps past 7
    m_r = rd_cyc.size();
    m_d = dlv_data.size();
    write_words(8'hD0, 8);
    wait_dlv(m_d + 8, 40, "t4a_timeout");
    write_words(8'hE0, 8);
    wait_dlv(m_d + 16, 40, "t4b_timeout");
    for (int i = 0; i < 16; i++) chk("t4_ram_addr", rd_addr[m_r+i], (3 + i) % 8);
    for (int i = 0; i < 8; i++) chk("t4_word_d", dlv_data[m_d+i], 8'(8'hD0 + i));
    for (int i = 0; i < 8; i++) chk("t4_word_e", dlv_data[m_d+8+i], 8'(8'hE0 + i));
    chk("t4_pop_count", pop_count, 27);

    // 5: flush with one word buffered and one in flight, pop in flush cycle
    out_ready = 1'b0;
    m_d = dlv_data.size();
    write_words(8'hB0, 8);
    repeat (4) step();           // B0,B1 buffered
    out_ready = 1'b1;
    step();                      // B0 out, B2 fetched
    flush = 1'b1;
    step();                      // B1 out (counted), B2 dropped
    flush = 1'b0;
    chk("t5_valid_after_flush", out_valid, 0);
    chk("t5_count_at_flush", dlv_data.size() - m_d, 2);
    chk("t5_flush_cycle_word", dlv_data[m_d+1], 8'hB1);
    wait_dlv(m_d + 7, 30, "t5_timeout");
    chk("t5_next_after_flush", dlv_data[m_d+2], 8'hB3);
    chk("t5_last", dlv_data[m_d+6], 8'hB7);
    chk("t5_pop_count", pop_count, 34);
    chk("t5_fifo_drained", cnt, 0);

    // 6: 65537 deliveries wrap pop_count to 1
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("t6_count_cleared", pop_count, 0);
    m_d = dlv_data.size();
    written = 0;
    k = 0;
    while (dlv_data.size() < m_d + 65537 && k < 70000) begin
      wr_en   = (written < 65537) && (cnt < 8);
      wr_data = 8'(written);
      if (wr_en) written++;
      step();
      k++;
    end
    wr_en = 1'b0;
    chk("t6_timeout", dlv_data.size() - m_d, 65537);
    chk("t6_pop_count_wrap", pop_count, 1);
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
